// File: rtl/lb_miss_handler_if.sv
// Load-buffer / Dcache / memory-bus signal bundle for lb_miss_handler.
// slave = the miss handler, master = the surrounding lb, Dcache and memory.
interface lb_miss_handler_if #(
    parameter int LB_BITS      = 3,
    parameter int MEM_TAG_BITS = 4
);
    logic                    valid_request;
    logic [LB_BITS-1:0]      proc2Dcache_index;
    logic [63:0]             proc2Dcache_addr;
    logic                    mispredict;
    logic                    Dcache_req_successful;
    logic                    Dcache_valid;
    logic [63:0]             Dcache_data;
    logic [LB_BITS-1:0]      Dcache_index;
    logic                    Memory_valid;
    logic [63:0]             Memory_data;
    logic [LB_BITS-1:0]      Memory_index;
    logic [63:0]             cache_lookup_addr;
    logic                    cache_hit;
    logic [63:0]             cache_rd_data;
    logic                    fill_en;
    logic [63:0]             fill_addr;
    logic [63:0]             fill_data;
    logic [1:0]              proc2mem_command;
    logic [63:0]             proc2mem_addr;
    logic [MEM_TAG_BITS-1:0] mem2proc_response;
    logic [63:0]             mem2proc_data;
    logic [MEM_TAG_BITS-1:0] mem2proc_tag;
    logic                    mshr_full;

    modport slave (
        input  valid_request, proc2Dcache_index, proc2Dcache_addr, mispredict,
        input  cache_hit, cache_rd_data, mem2proc_response, mem2proc_data, mem2proc_tag,
        output Dcache_req_successful, Dcache_valid, Dcache_data, Dcache_index,
        output Memory_valid, Memory_data, Memory_index, cache_lookup_addr,
        output fill_en, fill_addr, fill_data, proc2mem_command, proc2mem_addr, mshr_full
    );

    modport master (
        output valid_request, proc2Dcache_index, proc2Dcache_addr, mispredict,
        output cache_hit, cache_rd_data, mem2proc_response, mem2proc_data, mem2proc_tag,
        input  Dcache_req_successful, Dcache_valid, Dcache_data, Dcache_index,
        input  Memory_valid, Memory_data, Memory_index, cache_lookup_addr,
        input  fill_en, fill_addr, fill_data, proc2mem_command, proc2mem_addr, mshr_full
    );
endinterface

// File: rtl/lb_miss_handler.sv
// Load miss handler: Dcache lookup, MSHR tracking, memory issue/return and fill.
// Define LB_MISS_MERGE_EN to merge misses to a block already in ISSUE or WAIT.
module lb_miss_handler #(
    parameter int MSHR_SIZE    = 4,
    parameter int LB_BITS      = 3,
    parameter int MEM_TAG_BITS = 4
) (
    input  logic             clock,
    input  logic             reset,
    lb_miss_handler_if.slave bus
);
    localparam int IW   = (MSHR_SIZE > 1) ? $clog2(MSHR_SIZE) : 1;
    localparam int LB_N = 1 << LB_BITS;

    localparam logic [2:0] EMPTY  = 3'd0;
    localparam logic [2:0] ISSUE  = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] DONE   = 3'd3;
    localparam logic [2:0] ZOMBIE = 3'd4;

    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_LOAD = 2'd1;

    logic [2:0]              state [MSHR_SIZE];
    logic [60:0]             blk   [MSHR_SIZE];
    logic [MEM_TAG_BITS-1:0] tag   [MSHR_SIZE];
    logic [63:0]             data  [MSHR_SIZE];
    logic [LB_N-1:0]         mask  [MSHR_SIZE];

    logic            any_empty, issue_valid, ret_hit, drain_valid, drain_found, merge_hit;
    logic [IW-1:0]   alloc_idx, issue_idx, ret_idx, drain_idx, merge_idx;
    logic [LB_BITS-1:0] drain_bit;
    logic [LB_N-1:0] req_onehot, drain_onehot;
    logic            accept, hit_accept, miss_alloc, merge_accept;

    // Lowest-index selection for every per-entry arbitration point
    always_comb begin
        any_empty   = 1'b0;
        alloc_idx   = '0;
        issue_valid = 1'b0;
        issue_idx   = '0;
        ret_hit     = 1'b0;
        ret_idx     = '0;
        drain_valid = 1'b0;
        drain_idx   = '0;
        for (int unsigned i = 0; i < MSHR_SIZE; i++) begin
            if (!any_empty && state[i] == EMPTY) begin
                any_empty = 1'b1;
                alloc_idx = IW'(i);
            end
            if (!issue_valid && state[i] == ISSUE) begin
                issue_valid = 1'b1;
                issue_idx   = IW'(i);
            end
            if (!ret_hit && bus.mem2proc_tag != '0 && tag[i] == bus.mem2proc_tag &&
                (state[i] == WAIT || state[i] == ZOMBIE)) begin
                ret_hit = 1'b1;
                ret_idx = IW'(i);
            end
            if (!drain_valid && state[i] == DONE) begin
                drain_valid = 1'b1;
                drain_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        drain_found = 1'b0;
        drain_bit   = '0;
        for (int unsigned b = 0; b < LB_N; b++) begin
            if (!drain_found && mask[drain_idx][b]) begin
                drain_found = 1'b1;
                drain_bit   = LB_BITS'(b);
            end
        end
        drain_onehot = LB_N'(1) << drain_bit;
    end

`ifdef LB_MISS_MERGE_EN
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int unsigned i = 0; i < MSHR_SIZE; i++) begin
            if (!merge_hit && (state[i] == ISSUE || state[i] == WAIT) &&
                blk[i] == bus.proc2Dcache_addr[63:3]) begin
                merge_hit = 1'b1;
                merge_idx = IW'(i);
            end
        end
    end
`else
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
    end
`endif

    always_comb begin
        req_onehot   = LB_N'(1) << bus.proc2Dcache_index;
        accept       = bus.valid_request && !bus.mispredict &&
                       (bus.cache_hit || any_empty || merge_hit);
        hit_accept   = accept && bus.cache_hit;
        merge_accept = accept && !bus.cache_hit && merge_hit;
        miss_alloc   = accept && !bus.cache_hit && !merge_hit;

        bus.Dcache_req_successful = accept;
        bus.cache_lookup_addr     = bus.proc2Dcache_addr;
        bus.proc2mem_command      = issue_valid ? CMD_LOAD : CMD_NONE;
        bus.proc2mem_addr         = issue_valid ? {blk[issue_idx], 3'b000} : '0;
        bus.mshr_full             = !any_empty;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < MSHR_SIZE; i++) begin
                state[i] <= EMPTY;
                blk[i]   <= '0;
                tag[i]   <= '0;
                data[i]  <= '0;
                mask[i]  <= '0;
            end
            bus.Dcache_valid <= 1'b0;
            bus.Dcache_data  <= '0;
            bus.Dcache_index <= '0;
            bus.Memory_valid <= 1'b0;
            bus.Memory_data  <= '0;
            bus.Memory_index <= '0;
            bus.fill_en      <= 1'b0;
            bus.fill_addr    <= '0;
            bus.fill_data    <= '0;
        end else begin
            bus.Dcache_valid <= hit_accept;
            if (hit_accept) begin
                bus.Dcache_data  <= bus.cache_rd_data;
                bus.Dcache_index <= bus.proc2Dcache_index;
            end
            bus.Memory_valid <= drain_valid && !bus.mispredict;
            if (drain_valid && !bus.mispredict) begin
                bus.Memory_data  <= data[drain_idx];
                bus.Memory_index <= drain_bit;
            end
            // Fill happens for both WAIT and ZOMBIE returns, even under mispredict
            bus.fill_en <= ret_hit;
            if (ret_hit) begin
                bus.fill_addr <= {blk[ret_idx], 3'b000};
                bus.fill_data <= bus.mem2proc_data;
            end

            for (int unsigned i = 0; i < MSHR_SIZE; i++) begin
                case (state[i])
                    EMPTY: if (miss_alloc && alloc_idx == IW'(i)) begin
                        state[i] <= ISSUE;
                        blk[i]   <= bus.proc2Dcache_addr[63:3];
                        mask[i]  <= req_onehot;
                    end
                    ISSUE: begin
                        if (bus.mispredict) begin
                            state[i] <= EMPTY;
                        end else if (issue_valid && issue_idx == IW'(i) &&
                                     bus.mem2proc_response != '0) begin
                            state[i] <= WAIT;
                            tag[i]   <= bus.mem2proc_response;
                        end
                        if (merge_accept && merge_idx == IW'(i))
                            mask[i] <= mask[i] | req_onehot;
                    end
                    WAIT: begin
                        // A return coinciding with mispredict still fills but has no consumer
                        if (ret_hit && ret_idx == IW'(i)) begin
                            data[i]  <= bus.mem2proc_data;
                            state[i] <= bus.mispredict ? EMPTY : DONE;
                        end else if (bus.mispredict) begin
                            state[i] <= ZOMBIE;
                        end
                        if (merge_accept && merge_idx == IW'(i))
                            mask[i] <= mask[i] | req_onehot;
                    end
                    DONE: begin
                        if (bus.mispredict) begin
                            state[i] <= EMPTY;
                        end else if (drain_valid && drain_idx == IW'(i)) begin
                            mask[i] <= mask[i] & ~drain_onehot;
                            if ((mask[i] & ~drain_onehot) == '0)
                                state[i] <= EMPTY;
                        end
                    end
                    ZOMBIE: if (ret_hit && ret_idx == IW'(i)) state[i] <= EMPTY;
                    default: state[i] <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lb_miss_handler.sv
// Directed table-driven bench for lb_miss_handler: hit, miss, full, retry,
// mispredict, alloc/free overlap, optional merge and mid-transaction reset.
module tb_lb_miss_handler;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    lb_miss_handler_if #(.LB_BITS(3), .MEM_TAG_BITS(4)) bus ();

    lb_miss_handler #(.MSHR_SIZE(4), .LB_BITS(3), .MEM_TAG_BITS(4)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        vr;
        logic [2:0]  idx;
        logic [63:0] addr;
        logic        hit;
        logic [63:0] rd;
        logic        misp;
        logic [3:0]  resp;
        logic [3:0]  tag;
        logic [63:0] md;
        logic        acc;
        logic [1:0]  cmd;
        logic [63:0] maddr;
        logic        dv;
        logic [63:0] dd;
        logic [2:0]  di;
        logic        mv;
        logic [63:0] mdo;
        logic [2:0]  mi;
        logic        fe;
        logic [63:0] fa;
        logic        full;
    } vec_t;

    vec_t tbl[$];
    int n_cmp   = 0;
    int n_bad   = 0;
    int n_loads = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.valid_request     = 1'b0;
        bus.proc2Dcache_index = '0;
        bus.proc2Dcache_addr  = '0;
        bus.mispredict        = 1'b0;
        bus.cache_hit         = 1'b0;
        bus.cache_rd_data     = '0;
        bus.mem2proc_response = '0;
        bus.mem2proc_data     = '0;
        bus.mem2proc_tag      = '0;
    endtask

    task automatic add(input vec_t v);
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs, check combinational outputs, then registered ones after the edge
    task automatic run_vec(input vec_t v, input string nm);
        @(negedge clock);
        bus.valid_request     = v.vr;
        bus.proc2Dcache_index = v.idx;
        bus.proc2Dcache_addr  = v.addr;
        bus.mispredict        = v.misp;
        bus.cache_hit         = v.hit;
        bus.cache_rd_data     = v.rd;
        bus.mem2proc_response = v.resp;
        bus.mem2proc_tag      = v.tag;
        bus.mem2proc_data     = v.md;
        #1;
        chk({nm, " req_successful"}, 64'(bus.Dcache_req_successful), 64'(v.acc));
        chk({nm, " proc2mem_command"}, 64'(bus.proc2mem_command), 64'(v.cmd));
        chk({nm, " proc2mem_addr"}, bus.proc2mem_addr, v.maddr);
        chk({nm, " cache_lookup_addr"}, bus.cache_lookup_addr, v.addr);
        if (bus.proc2mem_command == 2'd1 && bus.mem2proc_response != '0) n_loads++;
        @(posedge clock);
        #1;
        chk({nm, " Dcache_valid"}, 64'(bus.Dcache_valid), 64'(v.dv));
        if (v.dv) begin
            chk({nm, " Dcache_data"}, bus.Dcache_data, v.dd);
            chk({nm, " Dcache_index"}, 64'(bus.Dcache_index), 64'(v.di));
        end
        chk({nm, " Memory_valid"}, 64'(bus.Memory_valid), 64'(v.mv));
        if (v.mv) begin
            chk({nm, " Memory_data"}, bus.Memory_data, v.mdo);
            chk({nm, " Memory_index"}, 64'(bus.Memory_index), 64'(v.mi));
        end
        chk({nm, " fill_en"}, 64'(bus.fill_en), 64'(v.fe));
        if (v.fe) begin
            chk({nm, " fill_addr"}, bus.fill_addr, v.fa);
            chk({nm, " fill_data"}, bus.fill_data, v.md);
        end
        chk({nm, " mshr_full"}, 64'(bus.mshr_full), 64'(v.full));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        // inputs: vr idx addr hit rd misp resp tag md | acc cmd maddr | dv dd di mv mdo mi fe fa full
        add('{1,5,'h800,1,'h90,0,0,0,0,       1,0,0,       1,'h90,5,0,0,0,0,0,0});
        add('{1,2,'h808,0,0,0,0,0,0,          1,0,0,       0,0,0,0,0,0,0,0,0});
        add('{0,0,0,0,0,0,3,0,0,              0,1,'h808,   0,0,0,0,0,0,0,0,0});
        add('{0,0,0,0,0,0,0,3,'h55,           0,0,0,       0,0,0,0,0,0,1,'h808,0});
        add('{0,0,0,0,0,0,0,0,0,              0,0,0,       0,0,0,1,'h55,2,0,0,0});
        add('{0,0,0,0,0,0,0,0,0,              0,0,0,       0,0,0,0,0,0,0,0,0});
        add('{1,0,'h1000,0,0,0,0,0,0,         1,0,0,       0,0,0,0,0,0,0,0,0});
        add('{1,1,'h1008,0,0,0,0,0,0,         1,1,'h1000,  0,0,0,0,0,0,0,0,0});
        add('{1,3,'h1010,0,0,0,0,0,0,         1,1,'h1000,  0,0,0,0,0,0,0,0,0});
        add('{1,4,'h1018,0,0,0,0,0,0,         1,1,'h1000,  0,0,0,0,0,0,0,0,1});
        add('{1,6,'h1020,0,0,0,0,0,0,         0,1,'h1000,  0,0,0,0,0,0,0,0,1});
        add('{1,7,'h1028,1,'hABCD,0,0,0,0,    1,1,'h1000,  1,'hABCD,7,0,0,0,0,0,1});
        add('{1,7,'h1030,1,'h1,1,0,0,0,       0,1,'h1000,  0,0,0,0,0,0,0,0,0});
        add('{0,0,0,0,0,0,0,0,0,              0,0,0,       0,0,0,0,0,0,0,0,0});
        add('{1,3,'h2000,0,0,0,0,0,0,         1,0,0,       0,0,0,0,0,0,0,0,0});
        add('{0,0,0,0,0,0,0,0,0,              0,1,'h2000,  0,0,0,0,0,0,0,0,0});
        add('{0,0,0,0,0,0,0,0,0,              0,1,'h2000,  0,0,0,0,0,0,0,0,0});
        add('{0,0,0,0,0,0,0,0,0,              0,1,'h2000,  0,0,0,0,0,0,0,0,0});
        add('{0,0,0,0,0,0,7,0,0,              0,1,'h2000,  0,0,0,0,0,0,0,0,0});
        add('{0,0,0,0,0,0,0,0,0,              0,0,0,       0,0,0,0,0,0,0,0,0});
        add('{0,0,0,0,0,0,0,5,'h77,           0,0,0,       0,0,0,0,0,0,0,0,0});
        add('{0,0,0,0,0,0,0,7,'h1234,         0,0,0,       0,0,0,0,0,0,1,'h2000,0});
        add('{0,0,0,0,0,0,0,0,0,              0,0,0,       0,0,0,1,'h1234,3,0,0,0});
        add('{1,1,'h3000,0,0,0,0,0,0,         1,0,0,       0,0,0,0,0,0,0,0,0});
        add('{0,0,0,0,0,0,4,0,0,              0,1,'h3000,  0,0,0,0,0,0,0,0,0});
        add('{0,0,0,0,0,1,0,0,0,              0,0,0,       0,0,0,0,0,0,0,0,0});
        add('{0,0,0,0,0,0,0,4,'h99,           0,0,0,       0,0,0,0,0,0,1,'h3000,0});
        add('{0,0,0,0,0,0,0,0,0,              0,0,0,       0,0,0,0,0,0,0,0,0});
        add('{1,0,'h4000,0,0,0,0,0,0,         1,0,0,       0,0,0,0,0,0,0,0,0});
        add('{1,1,'h4008,0,0,0,0,0,0,         1,1,'h4000,  0,0,0,0,0,0,0,0,0});
        add('{1,2,'h4010,0,0,0,0,0,0,         1,1,'h4000,  0,0,0,0,0,0,0,0,0});
        add('{1,3,'h4018,0,0,0,0,0,0,         1,1,'h4000,  0,0,0,0,0,0,0,0,1});
        add('{0,0,0,0,0,1,0,0,0,              0,1,'h4000,  0,0,0,0,0,0,0,0,0});
        add('{1,2,'h5000,0,0,0,0,0,0,         1,0,0,       0,0,0,0,0,0,0,0,0});
        add('{0,0,0,0,0,0,9,0,0,              0,1,'h5000,  0,0,0,0,0,0,0,0,0});
        add('{0,0,0,0,0,0,0,9,'hAA,           0,0,0,       0,0,0,0,0,0,1,'h5000,0});
        add('{0,0,0,0,0,1,0,0,0,              0,0,0,       0,0,0,0,0,0,0,0,0});
        add('{0,0,0,0,0,0,0,0,0,              0,0,0,       0,0,0,0,0,0,0,0,0});
        add('{1,0,'h6000,0,0,0,0,0,0,         1,0,0,       0,0,0,0,0,0,0,0,0});
        add('{1,1,'h6008,0,0,0,2,0,0,         1,1,'h6000,  0,0,0,0,0,0,0,0,0});
        add('{1,2,'h6010,0,0,0,0,2,'hBB,      1,1,'h6008,  0,0,0,0,0,0,1,'h6000,0});
        add('{1,3,'h6018,0,0,0,0,0,0,         1,1,'h6008,  0,0,0,1,'hBB,0,0,0,0});
        add('{1,4,'h6020,0,0,0,0,0,0,         1,1,'h6008,  0,0,0,0,0,0,0,0,1});
        add('{1,5,'h6028,0,0,0,0,0,0,         0,1,'h6020,  0,0,0,0,0,0,0,0,1});
        add('{0,0,0,0,0,1,0,0,0,              0,1,'h6020,  0,0,0,0,0,0,0,0,0});
        add('{0,0,0,0,0,0,0,0,0,              0,0,0,       0,0,0,0,0,0,0,0,0});

        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clock);
        #1;
        chk("reset Dcache_valid", 64'(bus.Dcache_valid), 0);
        chk("reset Memory_valid", 64'(bus.Memory_valid), 0);
        chk("reset fill_en", 64'(bus.fill_en), 0);
        chk("reset mshr_full", 64'(bus.mshr_full), 0);
        chk("reset req_successful", 64'(bus.Dcache_req_successful), 0);
        chk("reset proc2mem_command", 64'(bus.proc2mem_command), 0);
        chk("reset proc2mem_addr", bus.proc2mem_addr, 0);
        chk("reset Dcache_data", bus.Dcache_data, 0);
        chk("reset Memory_data", bus.Memory_data, 0);
        chk("reset fill_addr", bus.fill_addr, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        // Two misses to the same block: merged into one LOAD or issued separately
        base = n_loads;
        run_vec('{1,1,'hA00,0,0,0,0,0,0,      1,0,0,       0,0,0,0,0,0,0,0,0}, "merge0");
        run_vec('{1,6,'hA04,0,0,0,0,0,0,      1,1,'hA00,   0,0,0,0,0,0,0,0,0}, "merge1");
        run_vec('{0,0,0,0,0,0,5,0,0,          0,1,'hA00,   0,0,0,0,0,0,0,0,0}, "merge2");
`ifdef LB_MISS_MERGE_EN
        run_vec('{0,0,0,0,0,0,6,0,0,          0,0,0,       0,0,0,0,0,0,0,0,0}, "merge3");
`else
        run_vec('{0,0,0,0,0,0,6,0,0,          0,1,'hA00,   0,0,0,0,0,0,0,0,0}, "merge3");
`endif
        run_vec('{0,0,0,0,0,0,0,5,'hDD,       0,0,0,       0,0,0,0,0,0,1,'hA00,0}, "merge4");
`ifdef LB_MISS_MERGE_EN
        run_vec('{0,0,0,0,0,0,0,6,'hDD,       0,0,0,       0,0,0,1,'hDD,1,0,0,0}, "merge5");
`else
        run_vec('{0,0,0,0,0,0,0,6,'hDD,       0,0,0,       0,0,0,1,'hDD,1,1,'hA00,0}, "merge5");
`endif
        run_vec('{0,0,0,0,0,0,0,0,0,          0,0,0,       0,0,0,1,'hDD,6,0,0,0}, "merge6");
        run_vec('{0,0,0,0,0,0,0,0,0,          0,0,0,       0,0,0,0,0,0,0,0,0}, "merge7");
`ifdef LB_MISS_MERGE_EN
        chk("merge load count", 64'(n_loads - base), 1);
`else
        chk("merge load count", 64'(n_loads - base), 2);
`endif

        // Reset while an entry waits on tag 8; the late return must be ignored
        run_vec('{1,0,'hB000,0,0,0,0,0,0,     1,0,0,       0,0,0,0,0,0,0,0,0}, "rst0");
        run_vec('{0,0,0,0,0,0,8,0,0,          0,1,'hB000,  0,0,0,0,0,0,0,0,0}, "rst1");
        @(negedge clock);
        drive_idle();
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midreset mshr_full", 64'(bus.mshr_full), 0);
        chk("midreset proc2mem_command", 64'(bus.proc2mem_command), 0);
        @(negedge clock);
        reset = 1'b0;
        run_vec('{0,0,0,0,0,0,0,8,'hEE,       0,0,0,       0,0,0,0,0,0,0,0,0}, "rst2");
        run_vec('{0,0,0,0,0,0,0,0,0,          0,0,0,       0,0,0,0,0,0,0,0,0}, "rst3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
